cmd_read: RTL and testbench

Receives SD command responses (R1/R1b/R3/R6/R7 as 48-bit, R2 as 136-bit) from the card on the CMD line. Sits directly downstream of `cmd_write` on the CMD line. Armed when a command transmission finishes, it then does the following:
- waits up to Ncr SD clocks for the start bit;
- shifts the response in on SD-clock rising edges;
- checks CRC7, end bit and command index;
- presents the response payload and error flags to the response/interrupt registers.

---
 rtl/sdhci_pkg.sv | 24 ++
 rtl/cmd_read_if.sv | 35 +++
 rtl/counter.sv | 24 ++
 rtl/crc7_check.sv | 30 +++
 rtl/cmd_read.sv | 158 +++++++++++++++
 tb/tb_cmd_read.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/sdhci_pkg.sv
// Shared SDHCI types and constants.
// Response framing and CRC7 polynomial.
package sdhci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RX_BITS,
    END_BIT,
    FINISH
  } rx_state_e;

  localparam int unsigned RspShortBits = 48;
  localparam int unsigned RspLongBits  = 136;

  // Bits shifted after the start bit,
  // up to and including CRC bit 1.
  localparam int unsigned RxShortBits = RspShortBits - 2;
  localparam int unsigned RxLongBits  = RspLongBits - 2;

  // x^7 + x^3 + 1, x^7 term implicit.
  localparam logic [6:0] Crc7Poly = 7'h09;

endpackage

// File: rtl/cmd_read_if.sv
// Response-receiver request/result bundle.
// master arms, slave reports.
interface cmd_read_if;
  import sdhci_pkg::*;

  logic         start_rx;
  logic         long_rsp;
  logic         check_crc;
  logic         check_index;
  logic [5:0]   cmd_nr;
  logic         busy;
  logic         rsp_valid;
  logic [119:0] rsp;
  logic         timeout_err;
  logic         crc_err;
  logic         end_bit_err;
  logic         index_err;

  modport master (
    output start_rx, long_rsp, check_crc,
    output check_index, cmd_nr,
    input  busy, rsp_valid, rsp,
    input  timeout_err, crc_err,
    input  end_bit_err, index_err
  );

  modport slave (
    input  start_rx, long_rsp, check_crc,
    input  check_index, cmd_nr,
    output busy, rsp_valid, rsp,
    output timeout_err, crc_err,
    output end_bit_err, index_err
  );

endinterface

// File: rtl/counter.sv
// Generic up-counter with synchronous clear.
// Clear wins over enable.
module counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= count_o + Width'(1);
    end
  end

endmodule

// File: rtl/crc7_check.sv
// Serial CRC7 (x^7+x^3+1), MSB first, init 0.
// Remainder is exposed for comparison.
module crc7_check
  import sdhci_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_en_i,
  input  logic       clear_i,
  input  logic       input_en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic fb;
  assign fb = bit_i ^ crc_o[6];

  // LFSR update on enabled SD-clock edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clear_i) begin
      crc_o <= '0;
    end else if (clk_en_i && input_en_i) begin
      crc_o <= {crc_o[5:0], 1'b0}
             ^ (fb ? Crc7Poly : 7'h00);
    end
  end

endmodule

// File: rtl/cmd_read.sv
// SD CMD-line response receiver.
// Start-bit wait, shift-in, CRC/end/index check.
module cmd_read
  import sdhci_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clk_en_p_i,
  input  logic         cmd_i,
  input  logic         start_rx_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  input  logic         check_index_i,
  input  logic [5:0]   cmd_nr_i,
  output logic         busy_o,
  output logic         rsp_valid_o,
  output logic [119:0] rsp_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  localparam int unsigned TW =
    $clog2(TimeoutCycles + 1);

  rx_state_e state, state_n;

  logic         lng, chk_crc, chk_idx;
  logic [5:0]   nr;
  // bits 133..1 of the frame once complete
  logic [132:0] sr;
  logic [7:0]   bcnt;
  logic [TW-1:0] tcnt;
  logic [6:0]   crc;

  logic arm, start_det, tmo_hit;
  logic last_bit, end_edge, in_cov;

  assign arm = (state == IDLE) && start_rx_i;
  assign start_det = (state == WAIT_START)
                  && clk_en_p_i && !cmd_i;
  assign tmo_hit = (state == WAIT_START)
                && clk_en_p_i && cmd_i
                && (tcnt == TW'(TimeoutCycles - 1));
  assign last_bit = (state == RX_BITS) && clk_en_p_i
    && (bcnt == (lng ? 8'(RxLongBits - 1)
                     : 8'(RxShortBits - 1)));
  assign end_edge = (state == END_BIT) && clk_en_p_i;

  // counter n receives frame bit (len-2-n);
  // short covers bits 46..8, long bits 127..8
  assign in_cov = lng ? (bcnt >= 8'd7 && bcnt <= 8'd126)
                      : (bcnt <= 8'd38);

  counter #(.Width(8)) u_bit_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (arm || start_det),
    .en_i    ((state == RX_BITS) && clk_en_p_i),
    .count_o (bcnt)
  );

  counter #(.Width(TW)) u_tmo_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (arm),
    .en_i    ((state == WAIT_START)
              && clk_en_p_i && cmd_i),
    .count_o (tcnt)
  );

  crc7_check u_crc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clk_en_i   (clk_en_p_i),
    .clear_i    (arm),
    .input_en_i ((state == RX_BITS) && in_cov),
    .bit_i      (cmd_i),
    .crc_o      (crc)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (arm) state_n = WAIT_START;
      WAIT_START: begin
        if (start_det)    state_n = RX_BITS;
        else if (tmo_hit) state_n = FINISH;
      end
      RX_BITS:    if (last_bit) state_n = END_BIT;
      END_BIT:    if (end_edge) state_n = FINISH;
      FINISH:     state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // config latch, shift register, result flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lng           <= 1'b0;
      chk_crc       <= 1'b0;
      chk_idx       <= 1'b0;
      nr            <= '0;
      sr            <= '0;
      rsp_o         <= '0;
      timeout_err_o <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      index_err_o   <= 1'b0;
    end else begin
      if (arm) begin
        lng           <= long_rsp_i;
        chk_crc       <= check_crc_i;
        chk_idx       <= check_index_i;
        nr            <= cmd_nr_i;
        timeout_err_o <= 1'b0;
        crc_err_o     <= 1'b0;
        end_bit_err_o <= 1'b0;
        index_err_o   <= 1'b0;
      end
      if ((state == RX_BITS) && clk_en_p_i) begin
        sr <= {sr[131:0], cmd_i};
      end
      if (tmo_hit) begin
        timeout_err_o <= 1'b1;
        rsp_o         <= '0;
      end
      if (end_edge) begin
        end_bit_err_o <= !cmd_i;
        crc_err_o     <= chk_crc && (crc != sr[6:0]);
        if (lng) begin
          index_err_o <= chk_idx
                      && (sr[132:127] != 6'h3f);
          rsp_o       <= sr[126:7];
        end else begin
          index_err_o <= chk_idx && (sr[44:39] != nr);
          rsp_o       <= {88'h0, sr[38:7]};
        end
      end
    end
  end

  assign busy_o = (state == WAIT_START)
               || (state == RX_BITS)
               || (state == END_BIT);
  assign rsp_valid_o = (state == FINISH);

endmodule

// File: tb/tb_cmd_read.sv
// Directed bench for cmd_read.
// Vector table plus timeout/abort sequences.
module tb_cmd_read;
  import sdhci_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clk_en = 1'b0;
  logic cmd = 1'b1;

  cmd_read_if bus ();

  cmd_read #(.TimeoutCycles(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clk_en_p_i    (clk_en),
    .cmd_i         (cmd),
    .start_rx_i    (bus.start_rx),
    .long_rsp_i    (bus.long_rsp),
    .check_crc_i   (bus.check_crc),
    .check_index_i (bus.check_index),
    .cmd_nr_i      (bus.cmd_nr),
    .busy_o        (bus.busy),
    .rsp_valid_o   (bus.rsp_valid),
    .rsp_o         (bus.rsp),
    .timeout_err_o (bus.timeout_err),
    .crc_err_o     (bus.crc_err),
    .end_bit_err_o (bus.end_bit_err),
    .index_err_o   (bus.index_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         lng;
    logic         cc;
    logic         ci;
    logic [5:0]   nr;
    logic [135:0] fr;
    logic [119:0] ersp;
    logic         ecrc;
    logic         eend;
    logic         eidx;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  int checks = 0;
  int failures = 0;

  localparam logic [119:0] Pay =
    120'h0123456789ABCDEF0123456789ABCD;

  task automatic chk(input string nm,
                     input logic [119:0] act,
                     input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               nm, act, exp);
    end
  endtask

  // CRC7 by polynomial long division over f[hi:lo]
  function automatic logic [6:0] crc_div(
    input logic [135:0] f, input int hi, input int lo);
    logic [142:0] r;
    r = '0;
    for (int i = hi; i >= lo; i--) r[i-lo+7] = f[i];
    for (int i = 142; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk_short(
    input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] f;
    f = '0;
    f[47:0] = {2'b00, idx, arg, 7'h00, 1'b1};
    f[7:1] = crc_div(f, 47, 8);
    return f;
  endfunction

  function automatic logic [135:0] mk_long(
    input logic [5:0] idx, input logic [119:0] p);
    logic [135:0] f;
    f = {2'b00, idx, p, 7'h00, 1'b1};
    f[7:1] = crc_div(f, 127, 8);
    return f;
  endfunction

  task automatic do_edge(input logic b);
    @(posedge clk); #1;
    cmd = b;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    cmd = 1'b1;
  endtask

  task automatic arm(input logic lng, input logic cc,
                     input logic ci, input logic [5:0] nr,
                     input logic with_edge);
    @(posedge clk); #1;
    bus.start_rx = 1'b1;
    bus.long_rsp = lng;
    bus.check_crc = cc;
    bus.check_index = ci;
    bus.cmd_nr = nr;
    clk_en = with_edge;
    cmd = 1'b0;
    @(posedge clk); #1;
    bus.start_rx = 1'b0;
    clk_en = 1'b0;
    cmd = 1'b1;
  endtask

  task automatic check_result(input int v,
                              input string tag);
    chk($sformatf("%s%0d_valid", tag, v),
        120'(bus.rsp_valid), 120'(1'b1));
    chk($sformatf("%s%0d_busy", tag, v),
        120'(bus.busy), 120'(1'b0));
    chk($sformatf("%s%0d_rsp", tag, v),
        bus.rsp, vt[v].ersp);
    chk($sformatf("%s%0d_err", tag, v),
        120'({bus.timeout_err, bus.crc_err,
              bus.end_bit_err, bus.index_err}),
        120'({1'b0, vt[v].ecrc,
              vt[v].eend, vt[v].eidx}));
  endtask

  task automatic run_vec(input int v);
    int n;
    n = vt[v].lng ? 136 : 48;
    arm(vt[v].lng, vt[v].cc, vt[v].ci, vt[v].nr, 1'b0);
    chk($sformatf("v%0d_busy_arm", v),
        120'(bus.busy), 120'(1'b1));
    repeat (3) do_edge(1'b1);
    for (int k = 0; k < n - 1; k++)
      do_edge(vt[v].fr[n-1-k]);
    chk($sformatf("v%0d_pre_end", v),
        120'({bus.busy, bus.rsp_valid}), 120'(2'b10));
    do_edge(vt[v].fr[0]);
    check_result(v, "v");
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", v),
        120'(bus.rsp_valid), 120'(1'b0));
  endtask

  initial begin
    logic [135:0] f;
    logic seen;

    bus.start_rx = 1'b0;
    bus.long_rsp = 1'b0;
    bus.check_crc = 1'b0;
    bus.check_index = 1'b0;
    bus.cmd_nr = '0;

    f = mk_short(6'd8, 32'h000001AA);
    vt[0] = '{1'b0, 1'b1, 1'b1, 6'd8, f,
              120'h1AA, 1'b0, 1'b0, 1'b0};
    f[2] = ~f[2];
    vt[1] = '{1'b0, 1'b1, 1'b1, 6'd8, f,
              120'h1AA, 1'b1, 1'b0, 1'b0};
    f = mk_short(6'h3f, 32'h80FF8000);
    f[7:1] = 7'h7f;
    vt[2] = '{1'b0, 1'b0, 1'b0, 6'd0, f,
              120'h80FF8000, 1'b0, 1'b0, 1'b0};
    f = mk_long(6'h3f, Pay);
    vt[3] = '{1'b1, 1'b1, 1'b1, 6'd2, f,
              Pay, 1'b0, 1'b0, 1'b0};
    f = mk_short(6'd8, 32'h000001AA);
    vt[4] = '{1'b0, 1'b1, 1'b1, 6'd9, f,
              120'h1AA, 1'b0, 1'b0, 1'b1};
    f[0] = 1'b0;
    vt[5] = '{1'b0, 1'b1, 1'b1, 6'd8, f,
              120'h1AA, 1'b0, 1'b1, 1'b0};
    f = mk_long(6'h01, Pay);
    vt[6] = '{1'b1, 1'b1, 1'b1, 6'd2, f,
              Pay, 1'b0, 1'b0, 1'b1};
    f = mk_short(6'd17, 32'hDEADBEEF);
    f[5] = ~f[5];
    vt[7] = '{1'b0, 1'b0, 1'b1, 6'd17, f,
              120'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    f[0] = 1'b0;
    vt[8] = '{1'b0, 1'b1, 1'b1, 6'd16, f,
              120'hDEADBEEF, 1'b1, 1'b1, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        120'({bus.busy, bus.rsp_valid, bus.timeout_err,
              bus.crc_err, bus.end_bit_err,
              bus.index_err}), 120'(0));
    chk("reset_rsp", bus.rsp, 120'h0);
    rst_ni = 1'b1;

    // edges in IDLE are ignored
    do_edge(1'b0);
    chk("idle_edge",
        120'({bus.busy, bus.rsp_valid}), 120'(0));

    for (int v = 0; v < NV; v++) run_vec(v);

    // timeout; arm cycle's edge is not counted
    arm(1'b0, 1'b1, 1'b1, 6'd8, 1'b1);
    repeat (63) do_edge(1'b1);
    chk("tmo_63",
        120'({bus.busy, bus.rsp_valid}), 120'(2'b10));
    do_edge(1'b1);
    chk("tmo_valid",
        120'({bus.busy, bus.rsp_valid}), 120'(2'b01));
    chk("tmo_flag", 120'({bus.timeout_err,
        bus.crc_err, bus.end_bit_err, bus.index_err}),
        120'(4'b1000));
    chk("tmo_rsp", bus.rsp, 120'h0);

    // start bit on edge 64 is accepted
    arm(1'b0, 1'b1, 1'b1, 6'd8, 1'b0);
    repeat (63) do_edge(1'b1);
    for (int k = 47; k >= 0; k--)
      do_edge(vt[0].fr[k]);
    check_result(0, "late_start");

    // start_rx while receiving is ignored
    arm(1'b0, 1'b1, 1'b1, 6'd8, 1'b0);
    for (int k = 47; k >= 28; k--)
      do_edge(vt[0].fr[k]);
    @(posedge clk); #1;
    bus.start_rx = 1'b1;
    bus.long_rsp = 1'b1;
    bus.cmd_nr = 6'd0;
    @(posedge clk); #1;
    bus.start_rx = 1'b0;
    for (int k = 27; k >= 0; k--)
      do_edge(vt[0].fr[k]);
    check_result(0, "rearm_ign");

    // reset mid-reception aborts
    arm(1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
    for (int k = 47; k >= 28; k--)
      do_edge(vt[0].fr[k]);
    rst_ni = 1'b0;
    #2;
    chk("rst_mid_outs",
        120'({bus.busy, bus.rsp_valid, bus.timeout_err,
              bus.crc_err, bus.end_bit_err,
              bus.index_err}), 120'(0));
    chk("rst_mid_rsp", bus.rsp, 120'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int k = 27; k >= 0; k--) begin
      do_edge(vt[0].fr[k]);
      if (bus.rsp_valid || bus.busy) seen = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    if (bus.rsp_valid) seen = 1'b1;
    chk("rst_no_valid", 120'(seen), 120'(1'b0));

    run_vec(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
